// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with PWM dimming,
// decimal points, leading-zero blanking and per-frame input shadowing.
module sevenseg_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned BRIGHT_W     = 2
) (
    input  logic                    clk_1k_i,
    input  logic                    rst_ni,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [BRIGHT_W-1:0]     brightness_i,
    input  logic                    blank_lz_i,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [6:0]              segments_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DwW  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned CmpW = $clog2(DWELL_CYCLES) + BRIGHT_W + 1;

    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
    localparam logic [DwW-1:0]  DwLast  = DwW'(DWELL_CYCLES - 1);

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [IdxW-1:0]         idx_q, idx_d;
    logic [DwW-1:0]          dwell_q, dwell_d;
    logic                    started_q;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [BRIGHT_W-1:0]     sh_bright_q, sh_bright_d;
    logic                    sh_lz_q, sh_lz_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_q, frame_d;

    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_chain;
    logic [3:0]              dig;
    logic [3:0]              cur;
    logic                    lit;
    logic                    show;

    // Slot sequencing; the shadow reloads only on the frame-start edge.
    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        load    = 1'b0;
        if (!started_q) begin
            idx_d   = '0;
            dwell_d = '0;
            load    = 1'b1;
        end else if (dwell_q == DwLast) begin
            dwell_d = '0;
            if (idx_q == IdxLast) begin
                idx_d = '0;
                load  = 1'b1;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end else begin
            dwell_d = dwell_q + DwW'(1);
        end
        sh_digits_d = load ? digits_i     : sh_digits_q;
        sh_en_d     = load ? digit_en_i   : sh_en_q;
        sh_dp_d     = load ? dp_i         : sh_dp_q;
        sh_bright_d = load ? brightness_i : sh_bright_q;
        sh_lz_d     = load ? blank_lz_i   : sh_lz_q;
    end

    // Zero chain walks from the top digit; disabled digits don't break it.
    always_comb begin
        blank      = '0;
        zero_chain = 1'b1;
        dig        = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            dig      = sh_digits_d[4*k +: 4];
            blank[k] = sh_lz_d && (k != 0) && (dig == 4'h0) && zero_chain;
            zero_chain = zero_chain && ((dig == 4'h0) || !sh_en_d[k]);
        end
    end

    always_comb begin
        cur  = sh_digits_d[4*idx_d +: 4];
        lit  = (CmpW'(dwell_d) << BRIGHT_W) <
               ((CmpW'(sh_bright_d) + CmpW'(1)) * CmpW'(DWELL_CYCLES));
        show = sh_en_d[idx_d] && !blank[idx_d] && lit;
        anode_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (show && (idx_d == IdxW'(k))) anode_d[k] = 1'b0;
        end
        seg_d   = show ? hex_font(cur) : 7'b1111111;
        dp_d    = show ? ~sh_dp_d[idx_d] : 1'b1;
        frame_d = load;
    end

    always_ff @(posedge clk_1k_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q       <= '0;
            dwell_q     <= '0;
            started_q   <= 1'b0;
            sh_digits_q <= '0;
            sh_en_q     <= '0;
            sh_dp_q     <= '0;
            sh_bright_q <= '0;
            sh_lz_q     <= 1'b0;
            anode_q     <= '1;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            started_q   <= 1'b1;
            sh_digits_q <= sh_digits_d;
            sh_en_q     <= sh_en_d;
            sh_dp_q     <= sh_dp_d;
            sh_bright_q <= sh_bright_d;
            sh_lz_q     <= sh_lz_d;
            anode_q     <= anode_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frame_q     <= frame_d;
        end
    end

    assign anode_o    = anode_q;
    assign segments_o = seg_q;
    assign dp_o       = dp_q;
    assign frame_o    = frame_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: frame-position reference model feeding a
// scoreboard queue, a per-slot vector table, and hand-written corner sequences.
module tb_sevenseg_scan_driver;

    localparam int ND   = 4;
    localparam int DW   = 4;
    localparam int BR_W = 2;
    localparam int F    = ND * DW;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  en;
    logic [3:0]  dpi;
    logic [1:0]  br;
    logic        lz;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dpo;
    logic        frame;

    logic        rst2_n;
    logic [31:0] digits2;
    logic [7:0]  en2;
    logic [7:0]  dp2;
    logic [1:0]  br2;
    logic        lz2;
    logic [7:0]  anode2;
    logic [6:0]  seg2;
    logic        dpo2;
    logic        frame2;

    sevenseg_scan_driver #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BRIGHT_W(BR_W)) dut (
        .clk_1k_i(clk), .rst_ni(rst_n), .digits_i(digits), .digit_en_i(en), .dp_i(dpi),
        .brightness_i(br), .blank_lz_i(lz), .anode_o(anode), .segments_o(seg),
        .dp_o(dpo), .frame_o(frame)
    );

    sevenseg_scan_driver #(.NUM_DIGITS(8), .DWELL_CYCLES(1), .BRIGHT_W(2)) dut2 (
        .clk_1k_i(clk), .rst_ni(rst2_n), .digits_i(digits2), .digit_en_i(en2), .dp_i(dp2),
        .brightness_i(br2), .blank_lz_i(lz2), .anode_o(anode2), .segments_o(seg2),
        .dp_o(dpo2), .frame_o(frame2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      en;
        logic [3:0]      dp;
        logic [1:0]      br;
        logic            lz;
        logic [3:0]      shown;
        logic [3:0][6:0] segs;
        logic [3:0]      dpx;
    } vec_t;

    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          p     = -1;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_en = '0;
    logic [3:0]  m_dp = '0;
    int          m_br = 0;
    logic        m_lz = 1'b0;
    vec_t        vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input int pos);
        exp_t       e;
        int         idx;
        int         dw;
        logic [3:0] v;
        bit         blanked;
        bit         shown;
        idx = pos / DW;
        dw  = pos % DW;
        v   = m_digits[idx*4 +: 4];
        blanked = 1'b0;
        if (m_lz && idx != 0 && v == 4'h0) begin
            blanked = 1'b1;
            for (int j = idx + 1; j < ND; j++)
                if (m_digits[j*4 +: 4] != 4'h0 && m_en[j]) blanked = 1'b0;
        end
        shown = m_en[idx] && !blanked && ((dw * (1 << BR_W)) < ((m_br + 1) * DW));
        e.anode = 4'hf;
        if (shown) e.anode[idx] = 1'b0;
        e.seg   = shown ? font[v] : 7'h7f;
        e.dp    = shown ? ~m_dp[idx] : 1'b1;
        e.frame = (pos == 0);
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        if (p < 0 || p == F - 1) begin
            p = 0;
            m_digits = digits;
            m_en = en;
            m_dp = dpi;
            m_br = int'(br);
            m_lz = lz;
        end else begin
            p++;
        end
        sb_q.push_back(model(p));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("anode", 32'(anode), 32'(e.anode));
        chk("segments", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dpo), 32'(e.dp));
        chk("frame", 32'(frame), 32'(e.frame));
    endtask

    task automatic align();
        while (p != F - 1) tick();
    endtask

    task automatic chk_blank(input string nm);
        chk({nm, "_anode"}, 32'(anode), 32'hf);
        chk({nm, "_seg"}, 32'(seg), 32'h7f);
        chk({nm, "_dp"}, 32'(dpo), 32'h1);
        chk({nm, "_frame"}, 32'(frame), 32'h0);
    endtask

    initial begin
        logic [3:0] ax;
        logic [7:0] a8;
        int         s;

        vecs[0] = '{16'h1234, 4'hf, 4'h0, 2'd3, 1'b0, 4'b1111,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
        vecs[1] = '{16'h0008, 4'h1, 4'h0, 2'd0, 1'b0, 4'b0001,
                    {7'h7f, 7'h7f, 7'h7f, 7'b0000000}, 4'b1111};
        vecs[2] = '{16'h0070, 4'hf, 4'h0, 2'd3, 1'b1, 4'b0011,
                    {7'h7f, 7'h7f, 7'b1111000, 7'b1000000}, 4'b1111};
        vecs[3] = '{16'h0070, 4'h7, 4'h0, 2'd3, 1'b1, 4'b0011,
                    {7'h7f, 7'h7f, 7'b1111000, 7'b1000000}, 4'b1111};
        vecs[4] = '{16'h1234, 4'hf, 4'b0100, 2'd3, 1'b0, 4'b1111,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011};
        vecs[5] = '{16'h0000, 4'hf, 4'h0, 2'd2, 1'b1, 4'b0001,
                    {7'h7f, 7'h7f, 7'h7f, 7'b1000000}, 4'b1111};
        vecs[6] = '{16'hCDEF, 4'hf, 4'h0, 2'd1, 1'b0, 4'b1111,
                    {7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}, 4'b1111};
        vecs[7] = '{16'h9AB0, 4'hf, 4'h0, 2'd3, 1'b1, 4'b1111,
                    {7'b0010000, 7'b0001000, 7'b0000011, 7'b1000000}, 4'b1111};
        vecs[8] = '{16'h0070, 4'hf, 4'b1001, 2'd3, 1'b1, 4'b0011,
                    {7'h7f, 7'h7f, 7'b1111000, 7'b1000000}, 4'b1110};

        digits = 16'h1234; en = 4'hf; dpi = '0; br = 2'd3; lz = 1'b0;
        digits2 = 32'h76543210; en2 = 8'hff; dp2 = '0; br2 = 2'd0; lz2 = 1'b0;
        rst_n = 1'b1;
        rst2_n = 1'b1;
        #1;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        #2;
        chk_blank("reset");
        @(posedge clk);
        #1;
        chk_blank("reset_held");

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first_anode", 32'(anode), 32'b1110);
        chk("first_frame", 32'(frame), 32'h1);

        for (int i = 0; i < 9; i++) begin
            digits = vecs[i].digits; en = vecs[i].en; dpi = vecs[i].dp;
            br = vecs[i].br; lz = vecs[i].lz;
            align();
            for (int c = 0; c < F; c++) begin
                tick();
                s = p / DW;
                if (p % DW == 0) begin
                    ax = 4'hf;
                    if (vecs[i].shown[s]) ax[s] = 1'b0;
                    chk($sformatf("vec%0d_anode", i), 32'(anode), 32'(ax));
                    chk($sformatf("vec%0d_seg", i), 32'(seg),
                        vecs[i].shown[s] ? 32'(vecs[i].segs[s]) : 32'h7f);
                    chk($sformatf("vec%0d_dp", i), 32'(dpo), 32'(vecs[i].dpx[s]));
                end else if (i == 1) begin
                    chk("dim_off_anode", 32'(anode), 32'hf);
                end
            end
        end

        // Mid-frame input change must not tear the frame.
        digits = 16'h1234; en = 4'hf; dpi = '0; br = 2'd3; lz = 1'b0;
        align();
        tick();
        for (int c = 0; c < 4; c++) tick();
        digits = 16'h5678;
        while (p != F - 1) tick();
        chk("notear_anode", 32'(anode), 32'b0111);
        chk("notear_seg", 32'(seg), 32'b1111001);
        tick();
        chk("newframe_frame", 32'(frame), 32'h1);
        chk("newframe_anode", 32'(anode), 32'b1110);
        chk("newframe_seg", 32'(seg), 32'b0000000);

        // Asynchronous reset in the middle of a slot.
        digits = 16'h1234;
        align();
        tick();
        while (p != 9) tick();
        chk("pre_rst_anode", 32'(anode), 32'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        chk_blank("midrst");
        p = -1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_anode", 32'(anode), 32'b1110);
        chk("post_rst_frame", 32'(frame), 32'h1);

        // 8 digits, single-cycle dwell.
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            a8 = 8'hff;
            a8[k % 8] = 1'b0;
            chk("n8_anode", 32'(anode2), 32'(a8));
            chk("n8_frame", 32'(frame2), (k % 8 == 0) ? 32'h1 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Parametrised time-multiplexed 7-segment scan driver for an N-digit common-anode display.
- Successor to the fixed 4-digit Basys3 driver. Adds:
  - configurable digit count and per-digit dwell time;
  - PWM brightness control;
  - decimal points;
  - leading-zero blanking;
  - frame-synchronous input shadowing, so a digit value never changes mid-frame (no tearing).
- Sits between game/score logic and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1 or more.
- DWELL_CYCLES, 4, clock cycles each digit slot lasts; legal range 1 or more.
- BRIGHT_W, 2, width of the brightness code; gives 2^BRIGHT_W levels.

Ports:
- clk_1k_i  in  1  scan clock.
- rst_ni  in  1  asynchronous active-low reset.
- digits_i  in  4*NUM_DIGITS  hex value per digit; digit k is bits [4k+3:4k]; digit 0 is rightmost.
- digit_en_i  in  NUM_DIGITS  per-digit enable.
- dp_i  in  NUM_DIGITS  per-digit decimal point request, active-high.
- brightness_i  in  BRIGHT_W  duty code; 0 is dimmest, all-ones is fully on.
- blank_lz_i  in  1  leading-zero blanking enable.
- anode_o  out  NUM_DIGITS  active-low digit select.
- segments_o  out  7  active-low segments, order gfedcba.
- dp_o  out  1  active-low decimal point.
- frame_o  out  1  high during the first slot of each frame.

Behaviour:
- Reset (async, on rst_ni low):
  - anode_o = all ones, segments_o = 7'b1111111, dp_o = 1, frame_o = 0.
  - Digit index idx = 0, dwell counter dwell = 0, started flag = 0.
  - Shadow registers cleared: all digits disabled, brightness 0, blank_lz 0.
- All outputs are registered. After each posedge they reflect the slot (idx, dwell) and shadow contents held after that edge.
- First posedge after reset release:
  - started <= 1.
  - Shadow loads digits_i, digit_en_i, dp_i, brightness_i, blank_lz_i.
  - Slot (0,0) is displayed and frame_o = 1.
- Each later posedge advances the slot:
  - dwell increments.
  - At DWELL_CYCLES-1, dwell wraps to 0 and idx increments.
  - When idx wraps from NUM_DIGITS-1 to 0, that same edge reloads the shadow and frame_o = 1.
  - frame_o is 0 in all other slots.
- Frame period is exactly NUM_DIGITS*DWELL_CYCLES cycles. With NUM_DIGITS=1 idx stays 0; with DWELL_CYCLES=1 dwell stays 0.
- Input changes are ignored until the next frame load. Inputs are sampled only at the frame-load edge.
- Brightness (computed at width $clog2(DWELL_CYCLES)+BRIGHT_W+1, no truncation):
  - lit = (dwell << BRIGHT_W) < (shadow_brightness+1)*DWELL_CYCLES.
  - All-ones code gives lit in every slot.
  - Defaults: code 0 lights 1 of 4 cycles; code 3 lights 4 of 4.
- Leading-zero blanking: when shadow blank_lz = 1, digit k is blanked if:
  - k is not 0 (digit 0 is never blanked), and
  - k's value is 0, and
  - every digit j > k is either value 0 or disabled. Disabled digits are transparent to the zero chain.
- A slot is shown when digit idx is enabled, not blanked, and lit:
  - anode_o has only bit idx = 0.
  - segments_o = hex font of the digit.
  - dp_o = ~dp[idx].
- Otherwise: anode_o = all ones, segments_o = 7'b1111111, dp_o = 1.
- At most one anode is low in any cycle.
- Hex font, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-frame: outputs blank immediately (asynchronously). After release, the sequence restarts from the first-posedge rule.

Test Plan:
- Defaults, brightness 3, all enabled, digits 4'h1,2,3,4 (digit0=4), blank_lz 0 → anode_o holds 1110 for 4 cycles with segments 0011001, then 1101/0110000, 1011/0100100, 0111/1111001. frame_o = 1 every 16 cycles.
- Brightness 0, digit0 = 8, enabled → anode 1110 with segments 0000000 only when dwell = 0; all-ones/1111111 for the other 3 cycles of the slot.
- blank_lz 1, digits 0,0,7,0 (digit3..0) → digits 3 and 2 dark. Digit 1 shows 1111000. Digit 0 shows 1000000. Same case with digit3 disabled gives the same result.
- Change digits_i mid-frame (cycle 5 of 16) → displayed values stay unchanged until frame_o rises, then take the new values.
- dp_i = 4'b0100, all digits enabled → dp_o = 0 only while anode_o = 1011.
- Assert rst_ni mid-slot at anode 1011 → outputs blank at once. After release, first edge shows anode 1110 with frame_o = 1. Also regress NUM_DIGITS=8, DWELL_CYCLES=1: 8-cycle frame, one-hot-low anode every cycle.
